// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA/loader port.
// Define ARB_STATS_EN to build the saturating CPU-stall statistics counter behind stall_count.
module data_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [2:0]  dma_funct3,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        mem_we,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [15:0] stall_count
);

    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_WAIT = 2'd1;
    localparam logic [1:0] D_ACK  = 2'd2;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic             dma_win;
    logic             cpu_grant;
    logic             mem_we_raw;

    // DMA may only overtake a busy CPU once it has lost STARVE_LIMIT cycles in a row.
    assign dma_win   = dma_req && (state != D_ACK) && (!cpu_req || starve_cnt == LIMIT);
    assign cpu_grant = cpu_req && !dma_win;
    assign cpu_stall = cpu_req && dma_win;
    assign cpu_rdata = cpu_grant ? mem_rd : 32'h0;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        mem_we_raw = 1'b0;
        mem_funct3 = 3'b010;
        mem_a      = 32'h0;
        mem_wd     = 32'h0;
        if (dma_win) begin
            mem_we_raw = dma_we;
            mem_funct3 = dma_funct3;
            mem_a      = dma_addr;
            mem_wd     = dma_wdata;
        end else if (cpu_grant) begin
            mem_we_raw = cpu_we;
            mem_funct3 = cpu_funct3;
            mem_a      = cpu_addr;
            mem_wd     = cpu_wdata;
        end
    end

    // A store granted while reset is held must not reach the memory.
    assign mem_we = mem_we_raw && RESETn;

    always_comb begin
        state_nxt = state;
        case (state)
            D_IDLE: begin
                if (dma_win)      state_nxt = D_ACK;
                else if (dma_req) state_nxt = D_WAIT;
            end
            D_WAIT: begin
                if (dma_win)      state_nxt = D_ACK;
                else if (!dma_req) state_nxt = D_IDLE;
            end
            D_ACK:   state_nxt = D_IDLE;
            default: state_nxt = D_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state      <= D_IDLE;
            starve_cnt <= '0;
            dma_ack    <= 1'b0;
            dma_rdata  <= 32'h0;
        end else begin
            state   <= state_nxt;
            dma_ack <= dma_win;
            if (dma_win) begin
                dma_rdata <= dma_we ? 32'h0 : mem_rd;
            end
            if (!dma_req || dma_win) begin
                starve_cnt <= '0;
            end else if (state != D_ACK && starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            stall_cnt_q <= 16'h0;
        end else if (cpu_stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a byte-addressed behavioural data memory.
// Stall-count expectations follow ARB_STATS_EN the same way the design does.
module tb_data_mem_arbiter;

    logic        CLK;
    logic        RESETn;
    logic        cpu_req;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req;
    logic        dma_we;
    logic [2:0]  dma_funct3;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [15:0] stall_count;

    int checks;
    int errors;

`ifdef ARB_STATS_EN
    localparam logic [31:0] EXP_STALLS = 32'd2;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

    data_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_funct3(dma_funct3),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .stall_count(stall_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural memory: little-endian, combinational read, write on posedge.
    logic [7:0]  mem [0:255];
    logic [7:0]  rd_a;
    logic [31:0] rd_w;

    always_comb begin
        rd_a = mem_a[7:0];
        rd_w = {mem[rd_a + 8'd3], mem[rd_a + 8'd2], mem[rd_a + 8'd1], mem[rd_a]};
        case (mem_funct3)
            3'b000:  mem_rd = {{24{mem[rd_a][7]}}, mem[rd_a]};
            3'b001:  mem_rd = {{16{mem[rd_a + 8'd1][7]}}, mem[rd_a + 8'd1], mem[rd_a]};
            3'b100:  mem_rd = {24'h0, mem[rd_a]};
            3'b101:  mem_rd = {16'h0, mem[rd_a + 8'd1], mem[rd_a]};
            default: mem_rd = rd_w;
        endcase
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'hEF;
        mem[8'h11] = 8'hBE;
        mem[8'h12] = 8'hAD;
        mem[8'h13] = 8'hDE;
        forever begin
            @(posedge CLK);
            if (mem_we) begin
                case (mem_funct3)
                    3'b000: mem[mem_a[7:0]] = mem_wd[7:0];
                    3'b001: begin
                        mem[mem_a[7:0]]         = mem_wd[7:0];
                        mem[mem_a[7:0] + 8'd1]  = mem_wd[15:8];
                    end
                    default: begin
                        mem[mem_a[7:0]]         = mem_wd[7:0];
                        mem[mem_a[7:0] + 8'd1]  = mem_wd[15:8];
                        mem[mem_a[7:0] + 8'd2]  = mem_wd[23:16];
                        mem[mem_a[7:0] + 8'd3]  = mem_wd[31:24];
                    end
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req    = req;
        cpu_we     = we;
        cpu_funct3 = f3;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
        dma_req    = req;
        dma_we     = we;
        dma_funct3 = f3;
        dma_addr   = addr;
        dma_wdata  = wdata;
    endtask

    // CPU streams LW 0x10 while DMA asks for LB 0x21: DMA loses 4 cycles, wins the 5th.
    task automatic run_starve(input string tag);
        @(negedge CLK);
        set_cpu(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        set_dma(1'b1, 1'b0, 3'b000, 32'h21, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check({tag, "_lose_stall"}, {31'h0, cpu_stall}, 32'h0);
            check({tag, "_lose_rdata"}, cpu_rdata, 32'hDEADBEEF);
            check({tag, "_lose_addr"}, mem_a, 32'h10);
            check({tag, "_lose_ack"}, {31'h0, dma_ack}, 32'h0);
            @(negedge CLK);
        end
        #1;
        check({tag, "_win_stall"}, {31'h0, cpu_stall}, 32'h1);
        check({tag, "_win_addr"}, mem_a, 32'h21);
        check({tag, "_win_f3"}, {29'h0, mem_funct3}, 32'h0);
        check({tag, "_win_cpu_rdata"}, cpu_rdata, 32'h0);
        @(negedge CLK);
        dma_req = 1'b0;
        #1;
        check({tag, "_ack"}, {31'h0, dma_ack}, 32'h1);
        check({tag, "_dma_rdata"}, dma_rdata, 32'h00000056);
        check({tag, "_cpu_back_stall"}, {31'h0, cpu_stall}, 32'h0);
        check({tag, "_cpu_back_rdata"}, cpu_rdata, 32'hDEADBEEF);
        @(negedge CLK);
        cpu_req = 1'b0;
        #1;
        check({tag, "_ack_clear"}, {31'h0, dma_ack}, 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESETn = 1'b0;
        set_cpu(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        set_dma(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        repeat (2) @(negedge CLK);
        #1;
        check("rst_ack", {31'h0, dma_ack}, 32'h0);
        check("rst_dma_rdata", dma_rdata, 32'h0);
        check("rst_stall_count", {16'h0, stall_count}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        RESETn = 1'b1;

        // Both idle: memory bus parked.
        @(negedge CLK);
        #1;
        check("idle_we", {31'h0, mem_we}, 32'h0);
        check("idle_f3", {29'h0, mem_funct3}, 32'h2);
        check("idle_addr", mem_a, 32'h0);
        check("idle_wd", mem_wd, 32'h0);

        // CPU-only load.
        @(negedge CLK);
        set_cpu(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        #1;
        check("cpu_lw_rdata", cpu_rdata, 32'hDEADBEEF);
        check("cpu_lw_stall", {31'h0, cpu_stall}, 32'h0);
        check("cpu_lw_ack", {31'h0, dma_ack}, 32'h0);
        @(negedge CLK);
        cpu_req = 1'b0;
        #1;
        check("cpu_lw_ack_after", {31'h0, dma_ack}, 32'h0);
        check("cpu_idle_rdata", cpu_rdata, 32'h0);

        // DMA-only store, then CPU reads it back.
        @(negedge CLK);
        set_dma(1'b1, 1'b1, 3'b010, 32'h20, 32'h12345678);
        #1;
        check("dma_sw_we", {31'h0, mem_we}, 32'h1);
        check("dma_sw_addr", mem_a, 32'h20);
        check("dma_sw_wd", mem_wd, 32'h12345678);
        check("dma_sw_ack_n", {31'h0, dma_ack}, 32'h0);
        @(negedge CLK);
        dma_req = 1'b0;
        #1;
        check("dma_sw_ack", {31'h0, dma_ack}, 32'h1);
        check("dma_sw_rdata", dma_rdata, 32'h0);
        @(negedge CLK);
        set_cpu(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        #1;
        check("dma_sw_ack_pulse", {31'h0, dma_ack}, 32'h0);
        check("cpu_lw_20", cpu_rdata, 32'h12345678);
        @(negedge CLK);
        cpu_req = 1'b0;

        run_starve("starve1");

        // DMA store abandoned after two losing cycles.
        @(negedge CLK);
        set_cpu(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        set_dma(1'b1, 1'b1, 3'b000, 32'h30, 32'h000000AA);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("drop_stall", {31'h0, cpu_stall}, 32'h0);
            check("drop_we", {31'h0, mem_we}, 32'h0);
            @(negedge CLK);
        end
        dma_req = 1'b0;
        #1;
        check("drop_ack0", {31'h0, dma_ack}, 32'h0);
        check("drop_we_after", {31'h0, mem_we}, 32'h0);
        @(negedge CLK);
        cpu_req = 1'b0;
        #1;
        check("drop_ack1", {31'h0, dma_ack}, 32'h0);

        // Counter must have cleared: the full 4-cycle starvation window repeats.
        run_starve("starve2");
        check("stall_count", {16'h0, stall_count}, EXP_STALLS);

        @(negedge CLK);
        set_cpu(1'b1, 1'b0, 3'b100, 32'h30, 32'h0);
        #1;
        check("drop_mem_untouched", cpu_rdata, 32'h0);

        // Reset asserted in the cycle a DMA store is granted.
        @(negedge CLK);
        cpu_req = 1'b0;
        set_dma(1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
        RESETn = 1'b0;
        #1;
        check("rst_grant_we", {31'h0, mem_we}, 32'h0);
        @(negedge CLK);
        dma_req = 1'b0;
        RESETn  = 1'b1;
        #1;
        check("rst_grant_ack", {31'h0, dma_ack}, 32'h0);
        check("rst_grant_rdata", dma_rdata, 32'h0);
        check("rst_grant_stats", {16'h0, stall_count}, 32'h0);
        @(negedge CLK);
        set_cpu(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        #1;
        check("rst_grant_mem", cpu_rdata, 32'h0);
        check("rst_grant_ack2", {31'h0, dma_ack}, 32'h0);
        @(negedge CLK);
        cpu_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
